apb_gpio_bridge_p: RTL and testbench

Parametrised APB4 slave that bridges PCLK-domain APB transfers onto the GPIO register-block bus. It generalises the fixed 32-bit, zero-wait APB interface in four ways: configurable address and data widths, byte strobes, register-side ack with wait states, and PSLVERR on decode errors or timeout. It sits between the APB fabric and the GPIO register block and forwards the GPIO interrupt as a registered IRQ.

---
 rtl/apb_gpio_pkg.sv | 28 ++
 rtl/apb_wait_timer.sv | 40 ++++
 rtl/apb_gpio_bridge_p.sv | 173 +++++++++++++++++
 tb/tb_apb_gpio_bridge_p.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/apb_gpio_pkg.sv
// rtl/apb_gpio_pkg.sv - shared state type, response codes and width helpers for the APB-to-GPIO bridge
package apb_gpio_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  // Only byte, halfword and word buses are supported
  function automatic bit dw_legal(input int dw);
    dw_legal = (dw == 8) || (dw == 16) || (dw == 32);
  endfunction

  // Low address bits that must be zero for a naturally aligned DW access
  function automatic logic [1:0] align_mask(input int dw);
    logic [1:0] m;
    m = 2'b00;
    if (dw == 32) m = 2'b11;
    else if (dw == 16) m = 2'b01;
    align_mask = m;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - wait-state counter that flags expiry on the TIMEOUT-th counted cycle
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Count value seen during the TIMEOUT-th enabled cycle (count starts at 0)
  localparam logic [TW-1:0] LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Clear has priority over counting; wrap is harmless because the FSM leaves on expiry
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/apb_gpio_bridge_p.sv
// rtl/apb_gpio_bridge_p.sv - APB4 slave forwarding decoded transfers to the GPIO register-block bus
module apb_gpio_bridge_p
  import apb_gpio_pkg::*;
#(
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = 32'hFFFF_0000,
  parameter int              REG_AW    = 8,
  parameter int              TIMEOUT   = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [AW-1:0]     PADDR,
  input  logic [DW-1:0]     PWDATA,
  input  logic [DW/8-1:0]   PSTRB,
  output logic              PREADY,
  output logic [DW-1:0]     PRDATA,
  output logic              PSLVERR,
  output logic              IRQ,
  output logic [REG_AW-1:0] gpio_addr,
  output logic [DW-1:0]     gpio_dat_i,
  output logic [DW/8-1:0]   gpio_sel,
  output logic              gpio_we,
  output logic              gpio_re,
  input  logic              gpio_ack,
  input  logic [DW-1:0]     gpio_dat_o,
  input  logic              gpio_int_o
);

  localparam int         SW         = DW / 8;
  localparam bit         DW_OK      = dw_legal(DW);
  localparam logic [1:0] ALIGN_MASK = align_mask(DW);

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic [REG_AW-1:0] addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     rdata_q;
  logic [SW-1:0]     sel_q;
  logic              write_q;
  logic              hit_q;
  logic              irq_q;

  logic setup;
  logic hit_now;
  logic latch;
  logic cap_rd;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;

  assign setup   = PSEL && !PENABLE;
  // An illegal data width never decodes, so every access errors out
  assign hit_now = DW_OK
                && (PADDR[AW-1:REG_AW] == BASE_ADDR[AW-1:REG_AW])
                && ((PADDR[1:0] & ALIGN_MASK) == 2'b00);

  // Next-state, register-bus strobes and APB completion for the transfer FSM
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    latch   = 1'b0;
    cap_rd  = 1'b0;
    tmr_en  = 1'b0;
    PREADY  = 1'b0;
    gpio_we = 1'b0;
    gpio_re = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          latch   = 1'b1;
          err_d   = RESP_OKAY;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        gpio_we = hit_q && write_q && (sel_q != '0);
        gpio_re = hit_q && !write_q;
        if (!PSEL) begin
          state_d = S_IDLE;
        end else if (!hit_q) begin
          err_d   = RESP_ERR;
          state_d = S_RESP;
        end else if (write_q && (sel_q == '0)) begin
          state_d = S_RESP;
        end else if (gpio_ack) begin
          cap_rd  = !write_q;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmr_en = 1'b1;
        if (!PSEL) begin
          state_d = S_IDLE;
        end else if (gpio_ack) begin
          cap_rd  = !write_q;
          state_d = S_RESP;
        end else if (tmr_expired) begin
          err_d   = RESP_ERR;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        PREADY  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and response-code registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      err_q   <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Transfer latch at setup, read-data capture on ack, and the IRQ register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
      write_q <= 1'b0;
      hit_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (latch) begin
        addr_q  <= PADDR[REG_AW-1:0];
        wdata_q <= PWDATA;
        sel_q   <= PWRITE ? PSTRB : {SW{1'b1}};
        write_q <= PWRITE;
        hit_q   <= hit_now;
        rdata_q <= '0;
      end else if (cap_rd) begin
        rdata_q <= gpio_dat_o;
      end
      irq_q <= gpio_int_o;
    end
  end

  assign tmr_clr = (state_q != S_WAIT);

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expired_o(tmr_expired)
  );

  assign PSLVERR    = (state_q == S_RESP) && (err_q == RESP_ERR);
  assign PRDATA     = ((state_q == S_RESP) && (err_q == RESP_OKAY) && !write_q) ? rdata_q : '0;
  assign gpio_addr  = addr_q;
  assign gpio_dat_i = wdata_q;
  assign gpio_sel   = sel_q;
  assign IRQ        = irq_q;

endmodule

// File: tb/tb_apb_gpio_bridge_p.sv
// tb/tb_apb_gpio_bridge_p.sv - scoreboard bench for apb_gpio_bridge_p with directed APB transfers
module tb_apb_gpio_bridge_p;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR, IRQ;
  logic [31:0] PRDATA;
  logic [7:0]  gpio_addr;
  logic [31:0] gpio_dat_i;
  logic [3:0]  gpio_sel;
  logic        gpio_we, gpio_re, gpio_ack;
  logic [31:0] gpio_dat_o;
  logic        gpio_int_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  apb_gpio_bridge_p #(
    .AW(32), .DW(32), .BASE_ADDR(32'hFFFF_0000), .REG_AW(8), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR), .IRQ(IRQ), .gpio_addr(gpio_addr), .gpio_dat_i(gpio_dat_i),
    .gpio_sel(gpio_sel), .gpio_we(gpio_we), .gpio_re(gpio_re), .gpio_ack(gpio_ack),
    .gpio_dat_o(gpio_dat_o), .gpio_int_o(gpio_int_o)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every PREADY must match the oldest expected completion
  always @(negedge PCLK) begin
    if (!PRESET && PREADY) begin
      if (sb.size() == 0) begin
        check("pready_unexpected", 32'(PREADY), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pready_cycle", 32'(cyc), 32'(e.cyc));
        check("pslverr", 32'(PSLVERR), 32'(e.err));
        check("prdata", PRDATA, e.rdata);
      end
    end
  end

  // One APB transfer; ack_at = cycle index after REQ at which gpio_ack pulses (-1 = never)
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int ack_at, input logic [31:0] rdat,
                      input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                      input logic exp_we, input logic exp_re, input string tag);
    exp_t e;
    int   c0;
    bit   done;
    @(posedge PCLK); #1;
    c0      = cyc;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    PSTRB   = strb;
    e.cyc   = c0 + 1 + exp_lat;
    e.err   = exp_err;
    e.rdata = exp_rd;
    sb.push_back(e);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    check({tag, "_we"}, 32'(gpio_we), 32'(exp_we));
    check({tag, "_re"}, 32'(gpio_re), 32'(exp_re));
    if (exp_we || exp_re) begin
      check({tag, "_addr"}, 32'(gpio_addr), {24'd0, addr[7:0]});
      check({tag, "_sel"}, 32'(gpio_sel), wr ? {28'd0, strb} : 32'hF);
      check({tag, "_dat_i"}, gpio_dat_i, wdata);
    end
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      gpio_ack   = (i == ack_at);
      gpio_dat_o = rdat;
      if (i == 1) check({tag, "_strobe_one_cycle"}, 32'({gpio_we, gpio_re}), 32'd0);
      @(negedge PCLK);
      if (PREADY) done = 1'b1;
      else begin
        @(posedge PCLK); #1;
      end
    end
    if (!done) check({tag, "_completed"}, 32'(done), 32'd1);
    @(posedge PCLK); #1;
    PSEL     = 1'b0;
    PENABLE  = 1'b0;
    gpio_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    gpio_ack = 1'b0; gpio_dat_o = '0; gpio_int_o = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check("reset_outputs", {13'd0, PREADY, PSLVERR, IRQ, gpio_we, gpio_re, gpio_sel, gpio_addr, |PRDATA, |gpio_dat_i}, 32'd0);
    PRESET = 1'b0;

    xfer(1'b1, 32'hFFFF_000C, 32'h0000_00C9, 4'hF, 0,  32'h0,         1,  1'b0, 32'h0,  1'b1, 1'b0, "wr_ack_req");
    xfer(1'b0, 32'hFFFF_0010, 32'h0,         4'h0, 3,  32'h0000_00C9, 4,  1'b0, 32'hC9, 1'b0, 1'b1, "rd_ack3");
    xfer(1'b1, 32'h1234_5678, 32'h0000_0055, 4'hF, -1, 32'h0,         1,  1'b1, 32'h0,  1'b0, 1'b0, "wr_miss");
    xfer(1'b1, 32'hFFFF_0002, 32'h0000_0077, 4'hF, -1, 32'h0,         1,  1'b1, 32'h0,  1'b0, 1'b0, "wr_misalign");
    xfer(1'b0, 32'hFFFF_0004, 32'h0,         4'h0, -1, 32'hDEAD_BEEF, 17, 1'b1, 32'h0,  1'b0, 1'b1, "rd_timeout");
    xfer(1'b0, 32'hFFFF_0004, 32'h0,         4'h0, 16, 32'h0000_005A, 17, 1'b0, 32'h5A, 1'b0, 1'b1, "rd_ack_at_limit");

    // Abort in WAIT, then a late ack that must be ignored
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'hFFFF_0010;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    gpio_ack = 1'b1; gpio_dat_o = 32'h0000_00AA;
    @(posedge PCLK); #1;
    gpio_ack = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      check("abort_no_pready", 32'(PREADY), 32'd0);
    end
    xfer(1'b1, 32'hFFFF_0020, 32'h0000_1234, 4'h3, 1, 32'h0, 2, 1'b0, 32'h0, 1'b1, 1'b0, "wr_after_abort");

    // Reset while waiting on the register block
    gpio_int_o = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'hFFFF_0004; PWDATA = 32'h0000_00A5;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("reset_in_wait", {13'd0, PREADY, PSLVERR, IRQ, gpio_we, gpio_re, gpio_sel, gpio_addr, |PRDATA, |gpio_dat_i}, 32'd0);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; gpio_int_o = 1'b0;

    // IRQ is gpio_int_o delayed by one register
    @(posedge PCLK); #1;
    gpio_int_o = 1'b1;
    @(negedge PCLK);
    check("irq_before_edge", 32'(IRQ), 32'd0);
    @(posedge PCLK); #1;
    gpio_int_o = 1'b0;
    check("irq_rise", 32'(IRQ), 32'd1);
    @(posedge PCLK); #1;
    check("irq_fall", 32'(IRQ), 32'd0);

    xfer(1'b1, 32'hFFFF_0008, 32'h0000_0033, 4'h0, -1, 32'h0, 1, 1'b0, 32'h0, 1'b0, 1'b0, "wr_strb0");

    repeat (3) @(posedge PCLK);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
